// File: rtl/scope_trig_pkg.sv
// Shared definitions for the scope trigger control port: register map and sizing helper.
// Optional interrupt support is enabled by defining SCOPE_TRIG_CTRL_IRQ_EN.
package scope_trig_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE   = 3'd6;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/scope_sync2.sv
// Parametrised-width two-flop synchroniser with asynchronous active-high reset.
// Shared by the scope status blocks.
module scope_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1_q;
  logic [WIDTH-1:0] stage2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= d;
      stage2_q <= stage1_q;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/scope_trig_ctrl_pio.sv
// Avalon-MM control/status port for the scope trigger path: persistent outputs, timed strobes,
// synchronised status with edge capture. Define SCOPE_TRIG_CTRL_IRQ_EN for the masked interrupt.
module scope_trig_ctrl_pio
  import scope_trig_pkg::*;
#(
  parameter int unsigned WIDTH     = 5,
  parameter logic [31:0] RESET_VAL = 32'd3,
  parameter int unsigned STATUS_W  = 4,
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [STATUS_W-1:0] status_in,
  output logic [WIDTH-1:0]    out_port,
  output logic [WIDTH-1:0]    pulse_out,
  output logic                irq
);

  localparam int unsigned      CntW     = clog2(PULSE_LEN) + 1;
  localparam logic [CntW-1:0]  CntLoad  = CntW'(PULSE_LEN - 1);
  localparam logic [WIDTH-1:0] OutReset = RESET_VAL[WIDTH-1:0];

  logic                wr;
  logic [WIDTH-1:0]    wd_out;
  logic [STATUS_W-1:0] wd_st;
  logic                unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd_out    = writedata[WIDTH-1:0];
  assign wd_st     = writedata[STATUS_W-1:0];
  assign unused_wd = ^writedata;

  // Persistent output register
  logic [WIDTH-1:0] out_q, out_d;

  always_comb begin
    out_d = out_q;
    if (wr) begin
      case (address)
        ADDR_DATA:   out_d = wd_out;
        ADDR_OUTSET: out_d = out_q | wd_out;
        ADDR_OUTCLR: out_d = out_q & ~wd_out;
        default:     ;
      endcase
    end
  end

  // Pulse engine: one shared counter, retrigger restarts the full length for every active bit
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             pulse_wr;

  assign pulse_wr = wr && (address == ADDR_PULSE) && (wd_out != '0);

  always_comb begin
    pulse_d = pulse_q;
    cnt_d   = cnt_q;
    if (pulse_wr) begin
      pulse_d = pulse_q | wd_out;
      cnt_d   = CntLoad;
    end else if (pulse_q != '0) begin
      if (cnt_q == '0) pulse_d = '0;
      else             cnt_d   = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= OutReset;
      pulse_q <= '0;
      cnt_q   <= '0;
    end else begin
      out_q   <= out_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_port  = out_q;
  assign pulse_out = pulse_q;

  // Status synchronisation and rising-edge capture
  logic [STATUS_W-1:0] status_sync;
  logic [STATUS_W-1:0] prev_q;
  logic [STATUS_W-1:0] rise;
  logic [STATUS_W-1:0] edge_q, edge_d;
  logic [STATUS_W-1:0] edge_clr;

  scope_sync2 #(
    .WIDTH(STATUS_W)
  ) u_status_sync (
    .clk  (clk),
    .reset(reset),
    .d    (status_in),
    .q    (status_sync)
  );

  assign rise     = status_sync & ~prev_q;
  assign edge_clr = (wr && (address == ADDR_EDGECAP)) ? wd_st : '0;
  // A rise in the same cycle as its clear keeps the bit set
  assign edge_d   = (edge_q & ~edge_clr) | rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      prev_q <= status_sync;
      edge_q <= edge_d;
    end
  end

  logic [STATUS_W-1:0] mask_rd;

`ifdef SCOPE_TRIG_CTRL_IRQ_EN
  logic [STATUS_W-1:0] mask_q;
  logic                irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr && (address == ADDR_IRQMASK)) mask_q <= wd_st;
      irq_q <= |(edge_q & mask_q);
    end
  end

  assign mask_rd = mask_q;
  assign irq     = irq_q;
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

  // Combinational read mux, valid regardless of chipselect
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(out_q);
      ADDR_STATUS:  readdata = 32'(status_sync);
      ADDR_IRQMASK: readdata = 32'(mask_rd);
      ADDR_EDGECAP: readdata = 32'(edge_q);
      ADDR_PULSE:   readdata = 32'(pulse_q);
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_scope_trig_ctrl_pio.sv
// Directed self-checking bench for scope_trig_ctrl_pio (WIDTH=5, RESET_VAL=3, PULSE_LEN=4).
module tb_scope_trig_ctrl_pio;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  status_in;
  logic [4:0]  out_port;
  logic [4:0]  pulse_out;
  logic        irq;

  int errors = 0;
  int checks = 0;

  scope_trig_ctrl_pio #(
    .WIDTH    (5),
    .RESET_VAL(32'd3),
    .STATUS_W (4),
    .PULSE_LEN(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .status_in (status_in),
    .out_port  (out_port),
    .pulse_out (pulse_out),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write lands on the next posedge and returns at the following negedge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  logic [31:0] rd;

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    status_in  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_out", 32'(out_port), 32'h3);
    check("rst_pulse", 32'(pulse_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    bus_read(3'd0, rd);
    check("rst_rd_data", rd, 32'h3);

    // Set / clear
    bus_write(3'd4, 32'h10);
    check("outset", 32'(out_port), 32'h13);
    bus_write(3'd5, 32'h01);
    check("outclr", 32'(out_port), 32'h12);
    bus_read(3'd4, rd);
    check("rd_outset", rd, 32'h0);
    bus_read(3'd5, rd);
    check("rd_outclr", rd, 32'h0);
    bus_read(3'd0, rd);
    check("rd_data", rd, 32'h12);

    // Single pulse: high exactly 4 cycles
    bus_write(3'd6, 32'h04);
    for (int i = 0; i < 4; i++) begin
      check("pulse_hi", 32'(pulse_out), 32'h04);
      bus_read(3'd6, rd);
      check("rd_pulse_hi", rd, 32'h04);
      @(negedge clk);
    end
    check("pulse_lo", 32'(pulse_out), 32'h0);
    bus_read(3'd6, rd);
    check("rd_pulse_lo", rd, 32'h0);

    // Zero write to pulse register is ignored
    bus_write(3'd6, 32'h0);
    check("pulse_zero_wr", 32'(pulse_out), 32'h0);

    // Retrigger two cycles in: both bits held for 4 further cycles
    bus_write(3'd6, 32'h04);
    check("retrig_first", 32'(pulse_out), 32'h04);
    @(negedge clk);
    check("retrig_second", 32'(pulse_out), 32'h04);
    bus_write(3'd6, 32'h01);
    for (int i = 0; i < 4; i++) begin
      check("retrig_hi", 32'(pulse_out), 32'h05);
      @(negedge clk);
    end
    check("retrig_lo", 32'(pulse_out), 32'h0);

    // Status synchronisation and edge capture
    status_in = 4'b0010;
    @(negedge clk);
    bus_read(3'd1, rd);
    check("status_1edge", rd, 32'h0);
    @(negedge clk);
    bus_read(3'd1, rd);
    check("status_2edge", rd, 32'h2);
    bus_read(3'd3, rd);
    check("edgecap_early", rd, 32'h0);
    @(negedge clk);
    bus_read(3'd3, rd);
    check("edgecap_set", rd, 32'h2);

    // Clear coinciding with a new rise: edge wins
    status_in = 4'b0000;
    repeat (4) @(negedge clk);
    status_in = 4'b0010;
    repeat (2) @(negedge clk);
    bus_write(3'd3, 32'h2);
    bus_read(3'd3, rd);
    check("edge_wins", rd, 32'h2);
    bus_write(3'd3, 32'h2);
    bus_read(3'd3, rd);
    check("edge_w1c", rd, 32'h0);

`ifdef SCOPE_TRIG_CTRL_IRQ_EN
    bus_write(3'd2, 32'h2);
    bus_read(3'd2, rd);
    check("rd_mask", rd, 32'h2);
    status_in = 4'b0011;
    repeat (5) @(negedge clk);
    check("irq_masked", 32'(irq), 32'h0);
    bus_read(3'd3, rd);
    check("edgecap_bit0", rd, 32'h1);
    status_in = 4'b0001;
    repeat (4) @(negedge clk);
    status_in = 4'b0011;
    repeat (3) @(negedge clk);
    check("irq_before", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'h1);
    bus_write(3'd3, 32'h2);
    check("irq_hold", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'h0);
`else
    bus_write(3'd2, 32'h2);
    bus_read(3'd2, rd);
    check("rd_mask_absent", rd, 32'h0);
    status_in = 4'b0011;
    repeat (5) @(negedge clk);
    check("irq_tied", 32'(irq), 32'h0);
    bus_read(3'd3, rd);
    check("edgecap_bit0", rd, 32'h1);
`endif

    // Reserved address
    bus_write(3'd7, 32'hFF);
    check("rsvd_wr", 32'(out_port), 32'h12);
    bus_read(3'd7, rd);
    check("rsvd_rd", rd, 32'h0);

    // Asynchronous reset mid-pulse
    bus_write(3'd0, 32'h1F);
    check("out_1f", 32'(out_port), 32'h1F);
    bus_write(3'd6, 32'h03);
    check("pulse_mid", 32'(pulse_out), 32'h03);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out", 32'(out_port), 32'h3);
    check("arst_pulse", 32'(pulse_out), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    bus_read(3'd3, rd);
    check("arst_edgecap", rd, 32'h0);
    bus_read(3'd1, rd);
    check("arst_status", rd, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
